// File: rtl/tiny_alu_pkg.sv
// Shared opcodes, default widths and scheduler state encoding for the tiny ALU cluster.
// Pure declarations: no latency, no flow control.
// Backpressure: not applicable.
package tiny_alu_pkg;

    localparam int DEF_NUM_REQ         = 4;
    localparam int DEF_INPUT_DATA_BITS = 8;
    localparam int DEF_OPCODE_BITS     = 3;
    localparam int DEF_TIMEOUT_CYCLES  = 7;
    localparam int CNT_BITS            = 8;

    localparam logic [2:0] OP_NOP = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_XOR = 3'd3;
    localparam logic [2:0] OP_MUL = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } sched_state_t;

endpackage

// File: rtl/tiny_alu_rr_arb.sv
// Rotate-priority picker: first requester after last_grant_i, wrapping modulo NUM_REQ.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the grant is used.
module tiny_alu_rr_arb #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_grant_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   grant_idx_o
);

    logic             found;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant_o     = '0;
        grant_idx_o = '0;
        found       = 1'b0;
        idx         = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = IDX_W'((int'(last_grant_i) + i) % NUM_REQ);
            if (!found && req_i[idx]) begin
                found       = 1'b1;
                grant_o[idx] = 1'b1;
                grant_idx_o = idx;
            end
        end
    end

endmodule

// File: rtl/tiny_alu_sched.sv
// Round-robin scheduler sharing one ALU between NUM_REQ requesters, one operation in flight.
// Latency: accept T, start T+1, done T+2, response T+3; timeout response at T+2+TIMEOUT_CYCLES.
// Backpressure: ready only in IDLE for the granted requester; responses cannot be stalled.
module tiny_alu_sched
    import tiny_alu_pkg::*;
#(
    parameter int NUM_REQ         = DEF_NUM_REQ,
    parameter int INPUT_DATA_BITS = DEF_INPUT_DATA_BITS,
    parameter int OPCODE_BITS     = DEF_OPCODE_BITS,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [NUM_REQ*INPUT_DATA_BITS-1:0]   req_a_i,
    input  logic [NUM_REQ*INPUT_DATA_BITS-1:0]   req_b_i,
    input  logic [NUM_REQ*OPCODE_BITS-1:0]       req_opcode_i,
    output logic [NUM_REQ-1:0]                   rsp_valid_o,
    output logic [2*INPUT_DATA_BITS-1:0]         rsp_result_o,
    output logic                                 rsp_error_o,
    output logic [INPUT_DATA_BITS-1:0]           alu_a_o,
    output logic [INPUT_DATA_BITS-1:0]           alu_b_o,
    output logic [OPCODE_BITS-1:0]               alu_opcode_o,
    output logic                                 alu_start_o,
    input  logic [2*INPUT_DATA_BITS-1:0]         alu_result_i,
    input  logic                                 alu_done_i
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int DW    = INPUT_DATA_BITS;
    localparam int RW    = 2 * INPUT_DATA_BITS;
    localparam logic [CNT_BITS-1:0] TO_CNT = CNT_BITS'(TIMEOUT_CYCLES);

    logic [DW-1:0]          a_arr  [NUM_REQ];
    logic [DW-1:0]          b_arr  [NUM_REQ];
    logic [OPCODE_BITS-1:0] op_arr [NUM_REQ];

    for (genvar n = 0; n < NUM_REQ; n++) begin : g_unpack
        assign a_arr[n]  = req_a_i[n*DW +: DW];
        assign b_arr[n]  = req_b_i[n*DW +: DW];
        assign op_arr[n] = req_opcode_i[n*OPCODE_BITS +: OPCODE_BITS];
    end

    sched_state_t           state_q;
    logic [IDX_W-1:0]       last_grant_q;
    logic [IDX_W-1:0]       gidx_q;
    logic [DW-1:0]          a_q;
    logic [DW-1:0]          b_q;
    logic [OPCODE_BITS-1:0] op_q;
    logic                   start_q;
    logic [CNT_BITS-1:0]    cnt_q;
    logic [CNT_BITS-1:0]    cnt_d;
    logic [NUM_REQ-1:0]     rsp_valid_q;
    logic [RW-1:0]          result_q;
    logic                   error_q;

    logic [NUM_REQ-1:0]     grant_oh;
    logic [IDX_W-1:0]       grant_idx;
    logic [NUM_REQ-1:0]     gidx_oh;
    logic                   accept;

    tiny_alu_rr_arb #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i        (req_valid_i),
        .last_grant_i (last_grant_q),
        .grant_o      (grant_oh),
        .grant_idx_o  (grant_idx)
    );

    // Reset gates ready so a request is never acknowledged in a cycle that drops it.
    assign accept      = (state_q == S_IDLE) && (|req_valid_i) && !reset_i;
    assign req_ready_o = accept ? grant_oh : '0;
    assign gidx_oh     = NUM_REQ'(1) << gidx_q;
    assign cnt_d       = cnt_q + CNT_BITS'(1);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q      <= S_IDLE;
            last_grant_q <= IDX_W'(NUM_REQ - 1);
            gidx_q       <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= '0;
            start_q      <= 1'b0;
            cnt_q        <= '0;
            rsp_valid_q  <= '0;
            result_q     <= '0;
            error_q      <= 1'b0;
        end else begin
            start_q     <= 1'b0;
            rsp_valid_q <= '0;
            case (state_q)
                S_IDLE: begin
                    if (|req_valid_i) begin
                        gidx_q       <= grant_idx;
                        last_grant_q <= grant_idx;
                        a_q          <= a_arr[grant_idx];
                        b_q          <= b_arr[grant_idx];
                        op_q         <= op_arr[grant_idx];
                        start_q      <= 1'b1;
                        state_q      <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= '0;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    cnt_q <= cnt_d;
                    // A done arriving on the last allowed cycle still wins over the timeout.
                    if (alu_done_i) begin
                        result_q    <= alu_result_i;
                        error_q     <= 1'b0;
                        rsp_valid_q <= gidx_oh;
                        state_q     <= S_RESP;
                    end else if (cnt_d == TO_CNT) begin
                        result_q    <= '0;
                        error_q     <= 1'b1;
                        rsp_valid_q <= gidx_oh;
                        state_q     <= S_RESP;
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign alu_a_o      = a_q;
    assign alu_b_o      = b_q;
    assign alu_opcode_o = op_q;
    assign alu_start_o  = start_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = result_q;
    assign rsp_error_o  = error_q;

endmodule

// File: doc/tiny_alu_sched.md
# tiny_alu_sched

Round-robin scheduler that shares one `tiny_alu` instance between `NUM_REQ` requesters. It accepts operations over per-requester valid/ready handshakes and issues exactly one ALU operation at a time. It waits for the ALU `done`, with a timeout for opcodes the ALU never completes, and returns the 16-bit result to the requester that issued the operation. The block sits between the client blocks and the ALU; it is the only driver of the ALU `start`, `opcode`, `a` and `b` inputs.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `INPUT_DATA_BITS`, 8: operand width; result width is 2*`INPUT_DATA_BITS`.
- `OPCODE_BITS`, 3: opcode width.
- `TIMEOUT_CYCLES`, 7: cycles to wait for `alu_done_i` after start before declaring an error (1..255).

Ports:
- `clk_i` in 1: the single clock.
- `reset_i` in 1: synchronous, active-high reset.
- `req_valid_i` in `NUM_REQ`: requester n presents an operation.
- `req_ready_o` out `NUM_REQ`: operation of requester n accepted this cycle; one-hot or zero.
- `req_a_i` in `NUM_REQ*INPUT_DATA_BITS`: packed operand a; slice n belongs to requester n.
- `req_b_i` in `NUM_REQ*INPUT_DATA_BITS`: packed operand b.
- `req_opcode_i` in `NUM_REQ*OPCODE_BITS`: packed opcode.
- `rsp_valid_o` out `NUM_REQ`: one-cycle response pulse to requester n; one-hot or zero.
- `rsp_result_o` out 2*`INPUT_DATA_BITS`: result, valid with any `rsp_valid_o` bit.
- `rsp_error_o` out 1: response is a timeout; `rsp_result_o` is 0 in that case.
- `alu_a_o`, `alu_b_o` out `INPUT_DATA_BITS`: ALU operands.
- `alu_opcode_o` out `OPCODE_BITS`: ALU opcode.
- `alu_start_o` out 1: ALU start.
- `alu_result_i` in 2*`INPUT_DATA_BITS`: ALU result.
- `alu_done_i` in 1: ALU done.

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - If any `req_valid_i` bit is set, grant index g is the first set bit searching from `last_grant+1` modulo `NUM_REQ`.
  - `req_ready_o[g]` = 1 combinationally in that cycle.
  - Latch g and the a, b and opcode slices of g; set `last_grant` = g; go to ISSUE.
- **ISSUE**: `alu_start_o` = 1 for exactly this cycle, driven with the latched operands. Clear the timeout counter. Go to WAIT.
- **WAIT**
  - `alu_start_o` = 0; the operand and opcode outputs hold their latched values.
  - If `alu_done_i` = 1: capture `alu_result_i`, error = 0, go to RESP.
  - Otherwise increment the counter; when it reaches `TIMEOUT_CYCLES`, set error = 1, result = 0, go to RESP.
- **RESP**
  - Drive `rsp_valid_o[g]` = 1 with the captured result and error; there is no response backpressure.
  - Go to IDLE. A new grant is evaluated no earlier than the next cycle.
- **Requester handshake**: a requester holds valid and its data stable until it sees ready. Deasserting valid before ready is allowed and withdraws the request.
- **Ignored inputs**: `alu_done_i` is ignored in IDLE, ISSUE and RESP.
- **Opcodes**: forwarded unchanged. Opcodes the ALU does not complete (5..7) end in a timeout error response.
- **Widths**: result is passed through at full 2*`INPUT_DATA_BITS`, never truncated. The counter is 8 bits.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE.
  - `last_grant` = `NUM_REQ`-1, so requester 0 has first priority.
  - Counter 0, captured result 0, error 0.
- **Reset mid-operation** (any state): the in-flight operation is dropped with no response. A late `alu_done_i` after reset lands in IDLE and is ignored.
- **Latency**: accept at cycle T, `alu_start_o` at T+1, `alu_done_i` at T+2 (registered ALU), `rsp_valid_o` at T+3. Next accept no earlier than T+4, so peak throughput is 1 operation per 4 cycles.
- **Timeout response**: `rsp_valid_o` with error at T+2+`TIMEOUT_CYCLES`.
- **Fairness**: with all requesters valid continuously, grants rotate 0,1,2,3,0,…
  - A single active requester is granted back-to-back.
  - A requester whose valid rises while another is being served waits for at most `NUM_REQ`-1 other grants.
- **Same-requester overlap**: a requester may present its next request in the cycle of its own `rsp_valid_o`. It is considered from the following IDLE cycle.

## Structure
- Package `tiny_alu_pkg` holds:
  - The opcode constants NOP=0, ADD=1, AND=2, XOR=3, MUL=4.
  - Default widths.
  - The FSM state enum `sched_state_t`.
- Sub-module `tiny_alu_rr_arb` is the combinational rotate-priority picker. Inputs: request vector and `last_grant`. Outputs: one-hot grant and binary index.
- `tiny_alu_sched` holds the FSM, operand latch, counter and response registers.

## Test plan
- Single requester, reset then requester 1 ADD a=200, b=100 → ready at T, `alu_start_o` at T+1 with a=200/b=100/op=1, `rsp_valid_o`=0010 at T+3, result=300, error=0.
- All four valid continuously with MUL a=255, b=255 → grant order 0,1,2,3,0, responses spaced 4 cycles, each result=65025.
- Requester 2 opcode 6 → `alu_start_o` asserted once, no done. `rsp_valid_o`=0100 with error=1 and result=0 exactly 2+`TIMEOUT_CYCLES` cycles after accept.
- `reset_i` during WAIT of an XOR from requester 3 → no `rsp_valid_o` is ever asserted. All outputs 0 next cycle, and the next grant goes to requester 0 if it is valid.
- Requester 0 withdraws valid before being granted while requester 1 stays valid → requester 1 is granted, with no spurious ready to requester 0.
- NOP a=5, b=7 from requester 0 → response result=0, error=0 at T+3.
